excess3_to_bcd_packer: RTL and testbench

- Reverse direction of the team's BCD-to-Excess-3 path.
- Accepts a stream of Excess-3 coded digits, most-significant first, over a valid/ready handshake.
- Decodes each digit to BCD and packs up to NDIGITS digits into one packed-BCD word, with a parallel binary equivalent.
- Emits one result word per number over a second valid/ready handshake; flags illegal Excess-3 codes.

---
 rtl/excess3_to_bcd_packer.sv | 121 ++++++++++++
 tb/tb_excess3_to_bcd_packer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/excess3_to_bcd_packer.sv
// ============================================================================
// excess3_to_bcd_packer : Excess-3 digit stream -> packed BCD + binary word
// Revision: 1.0
// ============================================================================
`default_nettype none

module excess3_to_bcd_packer #(
  parameter int NDIGITS = 4,
  parameter int BIN_W   = 14,
  parameter int CNT_W   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [3:0]             i_in_digit,
  input  logic                   i_in_last,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [4*NDIGITS-1:0]   o_out_bcd,
  output logic [BIN_W-1:0]       o_out_bin,
  output logic [CNT_W-1:0]       o_out_ndig,
  output logic                   o_out_err
);

  localparam logic [0:0]       c_ST_COLLECT = 1'b0;
  localparam logic [0:0]       c_ST_EMIT    = 1'b1;
  localparam logic [BIN_W-1:0] c_TEN        = BIN_W'(10);
  localparam logic [CNT_W-1:0] c_NDIG       = CNT_W'(NDIGITS);

  logic [0:0]           r_state;
  logic [0:0]           w_state_next;
  logic [4*NDIGITS-1:0] r_bcd_acc;
  logic [BIN_W-1:0]     r_bin_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_err;

  logic                 w_collect;
  logic                 w_accept;
  logic                 w_release;
  logic                 w_legal;
  logic [3:0]           w_bcd;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic [BIN_W-1:0]     w_bin_next;

  assign w_collect  = (r_state == c_ST_COLLECT);
  assign w_accept   = i_in_valid && w_collect;
  assign w_release  = !w_collect && i_out_ready;

  // Illegal codes flag the word and contribute a zero digit.
  assign w_legal    = (i_in_digit >= 4'h3) && (i_in_digit <= 4'hC);
  assign w_bcd      = w_legal ? (i_in_digit - 4'd3) : 4'd0;
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_bin_next = (r_bin_acc * c_TEN) + BIN_W'(w_bcd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_COLLECT: begin
        if (w_accept && (i_in_last || (w_cnt_inc == c_NDIG))) begin
          w_state_next = c_ST_EMIT;
        end
      end
      c_ST_EMIT: begin
        if (i_out_ready) begin
          w_state_next = c_ST_COLLECT;
        end
      end
      default: w_state_next = c_ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd_acc <= '0;
      r_bin_acc <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else if (w_release) begin
      r_bcd_acc <= '0;
      r_bin_acc <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      r_bcd_acc <= {r_bcd_acc[4*NDIGITS-5:0], w_bcd};
      r_bin_acc <= w_bin_next;
      r_cnt     <= w_cnt_inc;
      r_err     <= r_err | ~w_legal;
    end
  end

  // Result outputs read zero outside EMIT so the reset view is all-zero.
  always_comb begin
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_out_bcd   = '0;
    o_out_bin   = '0;
    o_out_ndig  = '0;
    o_out_err   = 1'b0;
    if (w_collect) begin
      o_in_ready  = 1'b1;
    end else begin
      o_out_valid = 1'b1;
      o_out_bcd   = r_bcd_acc;
      o_out_bin   = r_bin_acc;
      o_out_ndig  = r_cnt;
      o_out_err   = r_err;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_excess3_to_bcd_packer.sv
// ============================================================================
// tb_excess3_to_bcd_packer : directed scoreboard bench for excess3_to_bcd_packer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_excess3_to_bcd_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [3:0]  i_in_digit = 4'h0;
  logic        i_in_last = 1'b0;
  logic        o_out_valid;
  logic        i_out_ready = 1'b0;
  logic [15:0] o_out_bcd;
  logic [13:0] o_out_bin;
  logic [2:0]  o_out_ndig;
  logic        o_out_err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] bcd;
    logic [13:0] bin;
    logic [2:0]  ndig;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  excess3_to_bcd_packer #(.NDIGITS(4), .BIN_W(14), .CNT_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_digit  (i_in_digit),
    .i_in_last   (i_in_last),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_bcd   (o_out_bcd),
    .o_out_bin   (o_out_bin),
    .o_out_ndig  (o_out_ndig),
    .o_out_err   (o_out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [15:0] bcd, input logic [13:0] bin,
                          input logic [2:0] ndig, input logic err);
    exp_t e;
    e.bcd = bcd; e.bin = bin; e.ndig = ndig; e.err = err;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; presents one digit and returns at the next negedge.
  task automatic send(input logic [3:0] dig, input logic lst);
    int n = 0;
    while (!o_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_send", {31'd0, o_in_ready}, 32'd1);
    i_in_valid = 1'b1;
    i_in_digit = dig;
    i_in_last  = lst;
    @(negedge clk);
    i_in_valid = 1'b0;
    i_in_last  = 1'b0;
  endtask

  // immediate=1 demands out_valid already high (one-cycle latency check).
  task automatic get_result(input string tag, input bit immediate);
    int   n = 0;
    exp_t e;
    if (immediate) begin
      chk({tag, "_latency"}, {31'd0, o_out_valid}, 32'd1);
    end else begin
      while (!o_out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk({tag, "_valid_wait"}, {31'd0, o_out_valid}, 32'd1);
    end
    if (exp_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_bcd"},  {16'd0, o_out_bcd},  {16'd0, e.bcd});
      chk({tag, "_bin"},  {18'd0, o_out_bin},  {18'd0, e.bin});
      chk({tag, "_ndig"}, {29'd0, o_out_ndig}, {29'd0, e.ndig});
      chk({tag, "_err"},  {31'd0, o_out_err},  {31'd0, e.err});
    end
    i_out_ready = 1'b1;
    @(negedge clk);
    i_out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, o_out_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, o_in_ready}, 32'd1);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, o_in_ready},  32'd1);
    chk("rst_out_bcd",   {16'd0, o_out_bcd},   32'd0);
    chk("rst_out_bin",   {18'd0, o_out_bin},   32'd0);
    chk("rst_out_ndig",  {29'd0, o_out_ndig},  32'd0);
    chk("rst_out_err",   {31'd0, o_out_err},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1234
    push_exp(16'h1234, 14'd1234, 3'd4, 1'b0);
    send(4'h4, 1'b0); send(4'h5, 1'b0); send(4'h6, 1'b0); send(4'h7, 1'b1);
    get_result("w1234", 1'b1);

    // 90
    push_exp(16'h0090, 14'd90, 3'd2, 1'b0);
    send(4'hC, 1'b0); send(4'h3, 1'b1);
    get_result("w90", 1'b1);

    // illegal second digit, then a clean word clears the flag
    push_exp(16'h0010, 14'd10, 3'd2, 1'b1);
    send(4'h4, 1'b0); send(4'hF, 1'b1);
    get_result("w_err", 1'b1);
    push_exp(16'h0003, 14'd3, 3'd1, 1'b0);
    send(4'h6, 1'b1);
    get_result("w3_after_err", 1'b1);

    // low illegal code
    push_exp(16'h0000, 14'd0, 3'd1, 1'b1);
    send(4'h1, 1'b1);
    get_result("w_err_low", 1'b1);

    // auto-termination at NDIGITS, next digit starts a new word
    push_exp(16'h9999, 14'd9999, 3'd4, 1'b0);
    send(4'hC, 1'b0); send(4'hC, 1'b0); send(4'hC, 1'b0); send(4'hC, 1'b0);
    get_result("w9999_auto", 1'b1);
    push_exp(16'h0001, 14'd1, 3'd1, 1'b0);
    send(4'h4, 1'b1);
    get_result("w1_after_auto", 1'b1);

    // backpressure with a digit presented during EMIT
    push_exp(16'h0001, 14'd1, 3'd1, 1'b0);
    send(4'h4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      i_in_valid = 1'b1;
      i_in_digit = 4'h9;
      chk("bp_valid",    {31'd0, o_out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, o_in_ready},  32'd0);
      chk("bp_bcd",      {16'd0, o_out_bcd},   32'h0001);
      chk("bp_bin",      {18'd0, o_out_bin},   32'd1);
      @(negedge clk);
    end
    i_in_valid = 1'b0;
    get_result("w_bp", 1'b1);
    push_exp(16'h0006, 14'd6, 3'd1, 1'b0);
    send(4'h9, 1'b1);
    get_result("w6_after_bp", 1'b1);

    // reset mid-word
    send(4'h5, 1'b0); send(4'h6, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, o_out_valid}, 32'd0);
    chk("midrst_in_ready",  {31'd0, o_in_ready},  32'd1);
    chk("midrst_bcd",       {16'd0, o_out_bcd},   32'd0);
    chk("midrst_bin",       {18'd0, o_out_bin},   32'd0);
    chk("midrst_ndig",      {29'd0, o_out_ndig},  32'd0);
    chk("midrst_err",       {31'd0, o_out_err},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_exp(16'h0004, 14'd4, 3'd1, 1'b0);
    send(4'h7, 1'b1);
    get_result("w4_after_rst", 1'b1);

    // reset while a result is pending
    send(4'h8, 1'b1);
    chk("emit_pending", {31'd0, o_out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("emitrst_out_valid", {31'd0, o_out_valid}, 32'd0);
    chk("emitrst_bin",       {18'd0, o_out_bin},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_exp(16'h0025, 14'd25, 3'd2, 1'b0);
    send(4'h5, 1'b0); send(4'h8, 1'b1);
    get_result("w25_after_emitrst", 1'b1);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
